// File: rtl/enable_data_pkg.sv
// Shared types and the channel legality rule for the enable/data arbiter.
// The legality check is width-generic up to 32 bits; callers zero-extend their data.
package enable_data_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  localparam int ERR_CNT_W  = 16;
  localparam int MAX_DATA_W = 32;

  // A beat may only be presented with the enable high if it is non-zero and even.
  function automatic logic data_is_legal(input logic [MAX_DATA_W-1:0] data);
    return (data != '0) && (data[0] == 1'b0);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after rr_ptr wins.
// Zero latency; no flow control of its own.
module rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx
);

  int idx;

  // Walk offsets from the far end so the closest requester to rr_ptr is written last.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    idx       = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (req[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
        grant_idx  = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/enable_data_arbiter.sv
// Round-robin burst arbiter onto one registered enable/data channel; illegal beats are dropped and counted.
// Grant costs one idle cycle, data appears one cycle after transfer; req_ready is held low while the output slot stalls.
module enable_data_arbiter
  import enable_data_pkg::*;
#(
  parameter  int NUM_REQ   = 4,
  parameter  int DATA_W    = 8,
  parameter  int MAX_BURST = 4,
  localparam int ID_W      = $clog2(NUM_REQ)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic                        out_enable,
  output logic [DATA_W-1:0]           out_data,
  output logic [ID_W-1:0]             out_id,
  input  logic                        out_ready,
  output logic [NUM_REQ-1:0]          rule_err,
  output logic [ERR_CNT_W-1:0]        err_count
);

  localparam int BC_W = $clog2(MAX_BURST + 1);

  arb_state_t         state, state_nxt;
  logic [ID_W-1:0]    owner, rr_ptr, grant_idx;
  logic [BC_W-1:0]    beat_cnt;
  logic [NUM_REQ-1:0] grant;
  logic [DATA_W-1:0]  owner_data;
  logic               owner_vld, slot_free, xfer, legal, burst_done, busy_exit, start;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req       (req_valid),
    .rr_ptr    (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  always_comb begin
    owner_data = '0;
    owner_vld  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (ID_W'(i) == owner) begin
        owner_data = req_data[i*DATA_W +: DATA_W];
        owner_vld  = req_valid[i];
      end
    end
  end

  assign slot_free  = !out_enable || out_ready;
  assign start      = (state == IDLE) && (|grant);
  assign xfer       = (state == BUSY) && owner_vld && slot_free;
  assign legal      = data_is_legal(MAX_DATA_W'(owner_data));
  assign burst_done = xfer && (beat_cnt == BC_W'(MAX_BURST - 1));
  assign busy_exit  = (state == BUSY) && (!owner_vld || burst_done);

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = (state == BUSY) && (ID_W'(i) == owner) && slot_free;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = BUSY;
      BUSY:    if (busy_exit) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner    <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
    end else begin
      if (start) begin
        owner    <= grant_idx;
        beat_cnt <= '0;
      end else if (xfer) begin
        beat_cnt <= beat_cnt + BC_W'(1);
      end
      if (busy_exit) rr_ptr <= (owner == ID_W'(NUM_REQ - 1)) ? '0 : owner + ID_W'(1);
    end
  end

  // Dropped beats never touch the output register, so a stalled legal beat stays intact.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_enable <= 1'b0;
      out_data   <= '0;
      out_id     <= '0;
      rule_err   <= '0;
      err_count  <= '0;
    end else begin
      if (xfer && legal) begin
        out_enable <= 1'b1;
        out_data   <= owner_data;
        out_id     <= owner;
      end else if (slot_free) begin
        out_enable <= 1'b0;
      end
      rule_err <= '0;
      if (xfer && !legal) begin
        rule_err[owner] <= 1'b1;
        if (err_count != '1) err_count <= err_count + ERR_CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_enable_data_arbiter.sv
// Directed bench for enable_data_arbiter: reset, bursts, rotation, rule drops, stall and async reset.
module tb_enable_data_arbiter;

  localparam int NUM_REQ   = 4;
  localparam int DATA_W    = 8;
  localparam int MAX_BURST = 4;
  localparam int ID_W      = 2;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      out_enable;
  logic [DATA_W-1:0]         out_data;
  logic [ID_W-1:0]           out_id;
  logic                      out_ready;
  logic [NUM_REQ-1:0]        rule_err;
  logic [15:0]               err_count;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [DATA_W-1:0] src_q [NUM_REQ][$];
  logic [DATA_W-1:0] log_data [$];
  logic [ID_W-1:0]   log_id [$];
  int                log_cyc [$];
  int                err_pulses [NUM_REQ];

  enable_data_arbiter #(
    .NUM_REQ   (NUM_REQ),
    .DATA_W    (DATA_W),
    .MAX_BURST (MAX_BURST)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .out_enable (out_enable),
    .out_data   (out_data),
    .out_id     (out_id),
    .out_ready  (out_ready),
    .rule_err   (rule_err),
    .err_count  (err_count)
  );

  always #5 clk = ~clk;

  task automatic drive();
    for (int i = 0; i < NUM_REQ; i++) begin
      req_valid[i] = (src_q[i].size() > 0);
      req_data[i*DATA_W +: DATA_W] = (src_q[i].size() > 0) ? src_q[i][0] : '0;
    end
  endtask

  // One clock: log handshakes at the edge, then drive the next inputs at the falling edge.
  task automatic step();
    @(posedge clk);
    if (rst_n && out_enable && out_ready) begin
      log_data.push_back(out_data);
      log_id.push_back(out_id);
      log_cyc.push_back(cyc);
    end
    for (int i = 0; i < NUM_REQ; i++)
      if (rst_n && req_valid[i] && req_ready[i]) void'(src_q[i].pop_front());
    cyc++;
    @(negedge clk);
    drive();
    #1;
    for (int i = 0; i < NUM_REQ; i++) if (rule_err[i]) err_pulses[i]++;
    checks++;
    if (out_enable && !(out_data != 0 && out_data[0] == 1'b0)) begin
      errors++;
      $display("FAIL out_legal: out_data=%0d with out_enable=1, required non-zero even", out_data);
    end
  endtask

  task automatic clear_logs();
    log_data.delete();
    log_id.delete();
    log_cyc.delete();
    for (int i = 0; i < NUM_REQ; i++) err_pulses[i] = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) src_q[i].delete();
    drive();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    clear_logs();
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) begin
      src_q[i].delete();
      src_q[i].push_back(8'd2);
    end
    drive();
    repeat (3) @(negedge clk);
    #1;
    checks++; if (out_enable !== 1'b0) begin errors++; $display("FAIL rst_out_enable: got %b exp 0", out_enable); end
    checks++; if (out_data !== 8'd0) begin errors++; $display("FAIL rst_out_data: got %0d exp 0", out_data); end
    checks++; if (out_id !== 2'd0) begin errors++; $display("FAIL rst_out_id: got %0d exp 0", out_id); end
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL rst_req_ready: got %b exp 0000", req_ready); end
    checks++; if (rule_err !== 4'b0000) begin errors++; $display("FAIL rst_rule_err: got %b exp 0000", rule_err); end
    checks++; if (err_count !== 16'd0) begin errors++; $display("FAIL rst_err_count: got %0d exp 0", err_count); end
    rst_n = 1'b1;
    clear_logs();
    step();
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL rst_first_grant: got %b exp 0001", req_ready); end
    step();
    checks++; if (out_enable !== 1'b1) begin errors++; $display("FAIL rst_first_enable: got %b exp 1", out_enable); end
    checks++; if (out_id !== 2'd0) begin errors++; $display("FAIL rst_first_id: got %0d exp 0", out_id); end
    checks++; if (out_data !== 8'd2) begin errors++; $display("FAIL rst_first_data: got %0d exp 2", out_data); end
  endtask

  task automatic test_single_burst();
    int exp_d [5] = '{4, 6, 8, 10, 12};
    int exp_dt [5] = '{0, 1, 2, 3, 5};
    do_reset();
    for (int k = 0; k < 5; k++) src_q[1].push_back(DATA_W'(exp_d[k]));
    drive();
    repeat (10) step();
    checks++;
    if (log_data.size() != 5) begin
      errors++; $display("FAIL burst_count: got %0d beats exp 5", log_data.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        checks++; if (log_data[k] !== DATA_W'(exp_d[k])) begin errors++; $display("FAIL burst_data[%0d]: got %0d exp %0d", k, log_data[k], exp_d[k]); end
        checks++; if (log_id[k] !== 2'd1) begin errors++; $display("FAIL burst_id[%0d]: got %0d exp 1", k, log_id[k]); end
        checks++; if (log_cyc[k] - log_cyc[0] != exp_dt[k]) begin errors++; $display("FAIL burst_timing[%0d]: got +%0d exp +%0d", k, log_cyc[k] - log_cyc[0], exp_dt[k]); end
      end
    end
  endtask

  task automatic test_round_robin();
    int b, j, exp_id, exp_dat;
    do_reset();
    for (int k = 0; k < 8; k++) begin
      src_q[0].push_back(DATA_W'(2 + 2 * k));
      src_q[2].push_back(DATA_W'(20 + 2 * k));
    end
    drive();
    repeat (26) step();
    checks++;
    if (log_data.size() != 16) begin
      errors++; $display("FAIL rr_count: got %0d beats exp 16", log_data.size());
    end else begin
      for (int k = 0; k < 16; k++) begin
        b = k / 4;
        j = k % 4;
        exp_id  = (b % 2 == 1) ? 2 : 0;
        exp_dat = ((b % 2 == 1) ? 20 : 2) + 2 * (4 * (b / 2) + j);
        checks++; if (log_id[k] !== ID_W'(exp_id)) begin errors++; $display("FAIL rr_id[%0d]: got %0d exp %0d", k, log_id[k], exp_id); end
        checks++; if (log_data[k] !== DATA_W'(exp_dat)) begin errors++; $display("FAIL rr_data[%0d]: got %0d exp %0d", k, log_data[k], exp_dat); end
      end
    end
  endtask

  task automatic test_rule_err();
    do_reset();
    src_q[3].push_back(8'd7);
    src_q[3].push_back(8'd0);
    src_q[3].push_back(8'd4);
    drive();
    step();
    checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL err_grant: got %b exp 1000", req_ready); end
    step();
    checks++; if (rule_err !== 4'b1000) begin errors++; $display("FAIL err_pulse1: got %b exp 1000", rule_err); end
    checks++; if (err_count !== 16'd1) begin errors++; $display("FAIL err_count1: got %0d exp 1", err_count); end
    checks++; if (out_enable !== 1'b0) begin errors++; $display("FAIL err_drop_enable: got %b exp 0", out_enable); end
    step();
    checks++; if (rule_err !== 4'b1000) begin errors++; $display("FAIL err_pulse2: got %b exp 1000", rule_err); end
    checks++; if (err_count !== 16'd2) begin errors++; $display("FAIL err_count2: got %0d exp 2", err_count); end
    step();
    checks++; if (rule_err !== 4'b0000) begin errors++; $display("FAIL err_pulse_clear: got %b exp 0000", rule_err); end
    checks++; if (out_enable !== 1'b1 || out_data !== 8'd4 || out_id !== 2'd3) begin
      errors++; $display("FAIL err_legal_beat: got en=%b data=%0d id=%0d exp en=1 data=4 id=3", out_enable, out_data, out_id);
    end
    repeat (4) step();
    checks++; if (err_pulses[3] != 2) begin errors++; $display("FAIL err_pulse_total: got %0d exp 2", err_pulses[3]); end
    checks++; if (err_pulses[0] + err_pulses[1] + err_pulses[2] != 0) begin errors++; $display("FAIL err_other_pulses: got %0d exp 0", err_pulses[0] + err_pulses[1] + err_pulses[2]); end
    checks++; if (err_count !== 16'd2) begin errors++; $display("FAIL err_count_final: got %0d exp 2", err_count); end
    checks++; if (log_data.size() != 1) begin errors++; $display("FAIL err_fwd_count: got %0d beats exp 1", log_data.size()); end
    else begin
      checks++; if (log_data[0] !== 8'd4) begin errors++; $display("FAIL err_fwd_data: got %0d exp 4", log_data[0]); end
    end
  endtask

  task automatic test_stall();
    int exp_d [4] = '{2, 4, 6, 8};
    do_reset();
    for (int k = 0; k < 4; k++) src_q[0].push_back(DATA_W'(exp_d[k]));
    drive();
    step();
    step();
    checks++; if (out_enable !== 1'b1 || out_data !== 8'd2) begin errors++; $display("FAIL stall_first: got en=%b data=%0d exp en=1 data=2", out_enable, out_data); end
    out_ready = 1'b0;
    #1;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL stall_ready0: got %b exp 0000", req_ready); end
    for (int c = 0; c < 3; c++) begin
      step();
      checks++; if (out_enable !== 1'b1 || out_data !== 8'd2 || out_id !== 2'd0) begin
        errors++; $display("FAIL stall_hold[%0d]: got en=%b data=%0d id=%0d exp en=1 data=2 id=0", c, out_enable, out_data, out_id);
      end
      checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL stall_ready[%0d]: got %b exp 0000", c, req_ready); end
    end
    out_ready = 1'b1;
    repeat (8) step();
    checks++;
    if (log_data.size() != 4) begin
      errors++; $display("FAIL stall_count: got %0d beats exp 4", log_data.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++; if (log_data[k] !== DATA_W'(exp_d[k])) begin errors++; $display("FAIL stall_data[%0d]: got %0d exp %0d", k, log_data[k], exp_d[k]); end
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    src_q[1].push_back(8'd2);
    drive();
    repeat (5) step();
    checks++; if (log_id.size() != 1) begin errors++; $display("FAIL arst_pre_count: got %0d beats exp 1", log_id.size()); end
    src_q[3].push_back(8'd2);
    src_q[3].push_back(8'd4);
    src_q[3].push_back(8'd6);
    drive();
    step();
    step();
    checks++; if (out_enable !== 1'b1 || out_id !== 2'd3) begin errors++; $display("FAIL arst_inflight: got en=%b id=%0d exp en=1 id=3", out_enable, out_id); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (out_enable !== 1'b0) begin errors++; $display("FAIL arst_enable_drop: got %b exp 0", out_enable); end
    checks++; if (out_data !== 8'd0) begin errors++; $display("FAIL arst_data_clear: got %0d exp 0", out_data); end
    for (int i = 0; i < NUM_REQ; i++) src_q[i].delete();
    drive();
    @(negedge clk);
    rst_n = 1'b1;
    clear_logs();
    src_q[1].push_back(8'd10);
    src_q[2].push_back(8'd20);
    drive();
    repeat (8) step();
    checks++;
    if (log_id.size() != 2) begin
      errors++; $display("FAIL arst_post_count: got %0d beats exp 2", log_id.size());
    end else begin
      checks++; if (log_id[0] !== 2'd1 || log_data[0] !== 8'd10) begin errors++; $display("FAIL arst_rr_first: got id=%0d data=%0d exp id=1 data=10", log_id[0], log_data[0]); end
      checks++; if (log_id[1] !== 2'd2 || log_data[1] !== 8'd20) begin errors++; $display("FAIL arst_rr_second: got id=%0d data=%0d exp id=2 data=20", log_id[1], log_data[1]); end
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_data  = '0;
    out_ready = 1'b1;
    test_reset();
    test_single_burst();
    test_round_robin();
    test_rule_err();
    test_stall();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
